// File: rtl/ds_burst_pkg.sv
// Shared types and helpers for the downstream burst router and its channel FIFOs.
package ds_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int CNT_W = 32;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Never returns 0 so that single-entry sizes still get a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ds_burst_ch_fifo.sv
// Single-clock first-word-fall-through FIFO; head reads as zero while empty.
module ds_burst_ch_fifo
  import ds_burst_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [ptr_w(FIFO_DEPTH):0]    count
);

  localparam int AW = ptr_w(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              do_rd;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_C);
  assign count   = count_reg;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + AW'(1);
      end
      case ({wr_en, do_rd})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ds_burst_router.sv
// Steers whole fixed-length bursts into per-channel FWFT FIFOs, dropping bursts that cannot fit.
// Optional per-channel admitted-burst counters: define DS_BURST_ROUTER_STAT_EN.
module ds_burst_router
  import ds_burst_pkg::*;
#(
  parameter int              DATA_W     = 128,
  parameter int              ID_W       = 8,
  parameter int              CH_NUM     = 4,
  parameter logic [ID_W-1:0] BASE_ID    = 8'h10,
  parameter int              BURST_LEN  = 16,
  parameter int              FIFO_DEPTH = 64
) (
  input  logic                     sys_clk_i,
  input  logic                     rst_i,
  input  logic [ID_W-1:0]          prased_des_id_i,
  input  logic                     ds_burst_valid_i,
  input  logic [DATA_W-1:0]        ds_burst_data_i,
  output logic [CH_NUM-1:0]        ch_valid_o,
  output logic [CH_NUM*DATA_W-1:0] ch_data_o,
  input  logic [CH_NUM-1:0]        ch_ready_i,
  output logic                     burst_active_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic [CNT_W-1:0]         id_err_cnt_o
`ifdef DS_BURST_ROUTER_STAT_EN
  ,
  output logic [CH_NUM*CNT_W-1:0]  ch_burst_cnt_o
`endif
);

  localparam int CH_W   = ptr_w(CH_NUM);
  localparam int CNT_FW = ptr_w(FIFO_DEPTH) + 1;
  localparam int BC_W   = ptr_w(BURST_LEN);
  localparam logic [BC_W-1:0]   BEAT_LAST = BC_W'(BURST_LEN - 1);
  localparam logic [CNT_FW-1:0] ROOM_MAX  = CNT_FW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [ID_W-1:0]   CH_NUM_ID = ID_W'(CH_NUM);

  state_t            state_reg, state_next;
  logic [BC_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic [CNT_W-1:0]  drop_cnt_reg, id_err_cnt_reg;
  logic [CH_NUM-1:0] wr_sel, fifo_empty, fifo_full;
  logic [CNT_FW-1:0] fifo_count [CH_NUM];
  logic [ID_W-1:0]   id_off;
  logic [CH_W-1:0]   id_ch;
  logic              in_range, room_ok, beat_last;
  logic              admit, id_err, room_err;

  // Underflow of IDs below BASE_ID wraps high and fails the range test.
  assign id_off    = prased_des_id_i - BASE_ID;
  assign id_ch     = id_off[CH_W-1:0];
  assign in_range  = (id_off < CH_NUM_ID);
  assign room_ok   = in_range && (fifo_count[id_ch] <= ROOM_MAX);
  assign beat_last = (beat_cnt_reg == BEAT_LAST);

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      beat_cnt_reg   <= '0;
      ch_reg         <= '0;
      drop_cnt_reg   <= '0;
      id_err_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      ch_reg       <= ch_next;
      if (room_err) drop_cnt_reg   <= sat_inc(drop_cnt_reg);
      if (id_err)   id_err_cnt_reg <= sat_inc(id_err_cnt_reg);
    end
  end

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    ch_next       = ch_reg;
    wr_sel        = '0;
    admit         = 1'b0;
    id_err        = 1'b0;
    room_err      = 1'b0;
    if (ds_burst_valid_i) begin
      beat_cnt_next = beat_last ? '0 : beat_cnt_reg + BC_W'(1);
      case (state_reg)
        ST_IDLE: begin
          if (!in_range) begin
            id_err     = 1'b1;
            state_next = beat_last ? ST_IDLE : ST_DROP;
          end else if (room_ok) begin
            admit         = 1'b1;
            wr_sel[id_ch] = 1'b1;
            ch_next       = id_ch;
            state_next    = beat_last ? ST_IDLE : ST_FWD;
          end else begin
            room_err   = 1'b1;
            state_next = beat_last ? ST_IDLE : ST_DROP;
          end
        end
        ST_FWD: begin
          wr_sel[ch_reg] = 1'b1;
          if (beat_last) state_next = ST_IDLE;
        end
        ST_DROP: begin
          if (beat_last) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign burst_active_o = (state_reg != ST_IDLE);
  assign drop_cnt_o     = drop_cnt_reg;
  assign id_err_cnt_o   = id_err_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      ds_burst_ch_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk     (sys_clk_i),
        .srst    (rst_i),
        .wr_en   (wr_sel[gi] & ~fifo_full[gi]),
        .wr_data (ds_burst_data_i),
        .rd_en   (ch_ready_i[gi]),
        .rd_data (ch_data_o[gi*DATA_W +: DATA_W]),
        .empty   (fifo_empty[gi]),
        .full    (fifo_full[gi]),
        .count   (fifo_count[gi])
      );
      assign ch_valid_o[gi] = ~fifo_empty[gi];

`ifdef DS_BURST_ROUTER_STAT_EN
      logic [CNT_W-1:0] burst_cnt_reg;
      always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
          burst_cnt_reg <= '0;
        end else if (admit && (id_ch == CH_W'(gi))) begin
          burst_cnt_reg <= sat_inc(burst_cnt_reg);
        end
      end
      assign ch_burst_cnt_o[gi*CNT_W +: CNT_W] = burst_cnt_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ds_burst_router.sv
// Directed bench for ds_burst_router: routing, ID/room drops, back-to-back bursts, mid-burst reset.
module tb_ds_burst_router;

  logic          sys_clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [7:0]    prased_des_id_i = '0;
  logic          ds_burst_valid_i = 1'b0;
  logic [127:0]  ds_burst_data_i = '0;
  logic [3:0]    ch_valid_o;
  logic [511:0]  ch_data_o;
  logic [3:0]    ch_ready_i = '0;
  logic          burst_active_o;
  logic [31:0]   drop_cnt_o;
  logic [31:0]   id_err_cnt_o;
`ifdef DS_BURST_ROUTER_STAT_EN
  logic [127:0]  ch_burst_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [127:0] obs_q [4][$];
  logic [3:0]   seen_valid = '0;

  ds_burst_router dut (
    .sys_clk_i        (sys_clk_i),
    .rst_i            (rst_i),
    .prased_des_id_i  (prased_des_id_i),
    .ds_burst_valid_i (ds_burst_valid_i),
    .ds_burst_data_i  (ds_burst_data_i),
    .ch_valid_o       (ch_valid_o),
    .ch_data_o        (ch_data_o),
    .ch_ready_i       (ch_ready_i),
    .burst_active_o   (burst_active_o),
    .drop_cnt_o       (drop_cnt_o),
    .id_err_cnt_o     (id_err_cnt_o)
`ifdef DS_BURST_ROUTER_STAT_EN
    ,
    .ch_burst_cnt_o   (ch_burst_cnt_o)
`endif
  );

  always #5 sys_clk_i = ~sys_clk_i;

  // Records every beat that will be popped at the next rising edge.
  always @(negedge sys_clk_i) begin
    seen_valid <= seen_valid | ch_valid_o;
    for (int c = 0; c < 4; c++) begin
      if (ch_valid_o[c] && ch_ready_i[c] && !rst_i) obs_q[c].push_back(ch_data_o[c*128 +: 128]);
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk_i); #1;
    end
  endtask

  task automatic beat(input logic [7:0] id, input int data);
    ds_burst_valid_i = 1'b1;
    prased_des_id_i  = id;
    ds_burst_data_i  = 128'(data);
    @(posedge sys_clk_i); #1;
    ds_burst_valid_i = 1'b0;
  endtask

  // ID driven only on the first beat; later beats carry junk to show it is latched.
  task automatic send_burst(input logic [7:0] id, input int base, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      beat((i == 0) ? id : 8'hFF, base + i);
      if (gaps && i != 15) idle($urandom_range(0, 2));
    end
  endtask

  task automatic clear_obs();
    for (int c = 0; c < 4; c++) obs_q[c].delete();
    seen_valid = '0;
  endtask

  initial begin
    idle(3);
    rst_i = 1'b0;
    chk("rst_valid", 128'(ch_valid_o), 128'h0);
    chk("rst_data", 128'(ch_data_o != '0), 128'h0);
    chk("rst_active", 128'(burst_active_o), 128'h0);
    chk("rst_drop", 128'(drop_cnt_o), 128'h0);
    chk("rst_iderr", 128'(id_err_cnt_o), 128'h0);

    // 1: single burst to channel 2
    ch_ready_i = 4'hF;
    clear_obs();
    beat(8'h12, 0);
    chk("t1_first_valid", 128'(ch_valid_o), 128'h4);
    chk("t1_first_data", ch_data_o[2*128 +: 128], 128'h0);
    chk("t1_active", 128'(burst_active_o), 128'h1);
    for (int i = 1; i < 16; i++) beat(8'h12, i);
    idle(4);
    chk("t1_count", 128'(obs_q[2].size()), 128'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("t1_beat%0d", i), obs_q[2][i], 128'(i));
    chk("t1_others", 128'(obs_q[0].size() + obs_q[1].size() + obs_q[3].size()), 128'd0);
    chk("t1_active_end", 128'(burst_active_o), 128'h0);
    chk("t1_drop", 128'(drop_cnt_o), 128'h0);
    chk("t1_iderr", 128'(id_err_cnt_o), 128'h0);

    // 2: out-of-range IDs above and below the window
    clear_obs();
    send_burst(8'h20, 'h100, 1'b0);
    send_burst(8'h0F, 'h200, 1'b0);
    idle(4);
    chk("t2_iderr", 128'(id_err_cnt_o), 128'd2);
    chk("t2_drop", 128'(drop_cnt_o), 128'd0);
    chk("t2_no_valid", 128'(seen_valid), 128'h0);

    // 3: fill channel 0 to exactly 64, fifth burst lacks room
    ch_ready_i = 4'b1110;
    clear_obs();
    for (int b = 0; b < 5; b++) send_burst(8'h10, 'h300 + b*16, 1'b0);
    idle(2);
    chk("t3_drop", 128'(drop_cnt_o), 128'd1);
    chk("t3_iderr", 128'(id_err_cnt_o), 128'd2);
    chk("t3_held", 128'(obs_q[0].size()), 128'd0);
    chk("t3_valid", 128'(ch_valid_o), 128'h1);
    ch_ready_i = 4'hF;
    idle(72);
    chk("t3_count", 128'(obs_q[0].size()), 128'd64);
    for (int i = 0; i < 64; i += 7) chk($sformatf("t3_beat%0d", i), obs_q[0][i], 128'('h300 + i));
    chk("t3_last", obs_q[0][63], 128'h33F);
    chk("t3_empty", 128'(ch_valid_o), 128'h0);

    // 4: back-to-back bursts with gaps inside each burst
    clear_obs();
    send_burst(8'h11, 'h400, 1'b1);
    beat(8'h13, 'h500);
    chk("t4_active_b2", 128'(burst_active_o), 128'h1);
    for (int i = 1; i < 16; i++) begin
      beat(8'hFF, 'h500 + i);
      idle($urandom_range(0, 2));
    end
    idle(4);
    chk("t4_ch1_count", 128'(obs_q[1].size()), 128'd16);
    chk("t4_ch3_count", 128'(obs_q[3].size()), 128'd16);
    for (int i = 0; i < 16; i += 5) begin
      chk($sformatf("t4_ch1_beat%0d", i), obs_q[1][i], 128'('h400 + i));
      chk($sformatf("t4_ch3_beat%0d", i), obs_q[3][i], 128'('h500 + i));
    end
    chk("t4_drop", 128'(drop_cnt_o), 128'd1);

    // 5: reset after seven beats, remainder treated as a fresh burst
    ch_ready_i = 4'h0;
    clear_obs();
    for (int i = 0; i < 7; i++) beat(8'h11, 'h600 + i);
    chk("t5_pre_valid", 128'(ch_valid_o), 128'h2);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    chk("t5_rst_valid", 128'(ch_valid_o), 128'h0);
    chk("t5_rst_active", 128'(burst_active_o), 128'h0);
    chk("t5_rst_drop", 128'(drop_cnt_o), 128'h0);
    chk("t5_rst_iderr", 128'(id_err_cnt_o), 128'h0);
    for (int i = 0; i < 9; i++) beat(8'h12, 'h700 + i);
    chk("t5_new_valid", 128'(ch_valid_o), 128'h4);
    chk("t5_mid_active", 128'(burst_active_o), 128'h1);
    for (int i = 9; i < 16; i++) beat(8'hFF, 'h700 + i);
    chk("t5_end_active", 128'(burst_active_o), 128'h0);
    ch_ready_i = 4'hF;
    idle(20);
    chk("t5_ch2_count", 128'(obs_q[2].size()), 128'd16);
    chk("t5_ch2_first", obs_q[2][0], 128'h700);
    chk("t5_ch2_last", obs_q[2][15], 128'h70F);
    chk("t5_ch1_count", 128'(obs_q[1].size()), 128'd0);

`ifdef DS_BURST_ROUTER_STAT_EN
    // 6: admitted-burst statistics
    for (int b = 0; b < 3; b++) send_burst(8'h13, 'h800 + b*16, 1'b0);
    send_burst(8'h40, 'h900, 1'b0);
    idle(4);
    chk("t6_ch3_bursts", 128'(ch_burst_cnt_o[3*32 +: 32]), 128'd3);
    chk("t6_ch2_bursts", 128'(ch_burst_cnt_o[2*32 +: 32]), 128'd1);
    chk("t6_iderr", 128'(id_err_cnt_o), 128'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
